// File: rtl/rsa_engine_arbiter.sv
// Round-robin arbiter sharing one RSA-4096 engine among NUM_REQ requesters.
// Grants one job at a time, pulses the engine start, and aborts hung or cancelled jobs.
module rsa_engine_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2,
  parameter logic [31:0] TIMEOUT = 32'd1000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               abort,
  input  logic               eng_done,
  output logic               eng_go,
  output logic               eng_rst,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic [NUM_REQ-1:0] ack,
  output logic [NUM_REQ-1:0] err,
  output logic               busy,
  output logic [7:0]         err_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e               state_q;
  logic [31:0]          wd_cnt_q;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic                 fail_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [IDX_W-1:0]     gnt_idx_q;
  logic                 eng_go_q;
  logic                 eng_rst_q;
  logic [NUM_REQ-1:0]   ack_q;
  logic [NUM_REQ-1:0]   err_q;
  logic                 busy_q;
  logic [7:0]           err_cnt_q;

  logic [IDX_W-1:0]     win_idx_d;
  logic [NUM_REQ-1:0]   win_oh_d;
  logic [IDX_W-1:0]     rr_ptr_d;
  logic [7:0]           err_cnt_d;
  logic                 timeout_hit;
  logic                 found;
  logic [IDX_W-1:0]     scan_idx;

  // First pending request at or above the round-robin pointer, wrapping.
  always_comb begin
    win_idx_d = '0;
    win_oh_d  = '0;
    found     = 1'b0;
    scan_idx  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      scan_idx = IDX_W'((int'(rr_ptr_q) + i) % int'(NUM_REQ));
      if (!found && req[scan_idx]) begin
        found              = 1'b1;
        win_idx_d          = scan_idx;
        win_oh_d[scan_idx] = 1'b1;
      end
    end
  end

  assign rr_ptr_d    = (gnt_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + IDX_W'(1);
  assign err_cnt_d   = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
  assign timeout_hit = (wd_cnt_q == TIMEOUT - 32'd1);

  // Completion wins over abort/timeout when they coincide in BUSY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      wd_cnt_q  <= '0;
      rr_ptr_q  <= '0;
      fail_q    <= 1'b0;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      eng_go_q  <= 1'b0;
      eng_rst_q <= 1'b0;
      ack_q     <= '0;
      err_q     <= '0;
      busy_q    <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      eng_go_q  <= 1'b0;
      eng_rst_q <= 1'b0;
      ack_q     <= '0;
      err_q     <= '0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_q   <= LAUNCH;
            gnt_q     <= win_oh_d;
            gnt_idx_q <= win_idx_d;
            eng_go_q  <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        LAUNCH: begin
          state_q  <= BUSY;
          wd_cnt_q <= '0;
        end
        BUSY: begin
          wd_cnt_q <= wd_cnt_q + 32'd1;
          if (eng_done) begin
            state_q <= RESP;
            fail_q  <= 1'b0;
            ack_q   <= gnt_q;
          end else if (abort || timeout_hit) begin
            state_q   <= RESP;
            fail_q    <= 1'b1;
            ack_q     <= gnt_q;
            err_q     <= gnt_q;
            eng_rst_q <= 1'b1;
          end
        end
        RESP: begin
          state_q   <= IDLE;
          gnt_q     <= '0;
          gnt_idx_q <= '0;
          busy_q    <= 1'b0;
          rr_ptr_q  <= rr_ptr_d;
          if (fail_q) begin
            err_cnt_q <= err_cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign eng_go  = eng_go_q;
  assign eng_rst = eng_rst_q;
  assign gnt     = gnt_q;
  assign gnt_idx = gnt_idx_q;
  assign ack     = ack_q;
  assign err     = err_q;
  assign busy    = busy_q;
  assign err_cnt = err_cnt_q;

endmodule
